wimpfi_txguard: RTL and testbench



---
 rtl/wimpfi_txguard.sv | 136 +++++++++++++
 tb/tb_wimpfi_txguard.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/wimpfi_txguard.sv
// Multi-channel transmit-enable guard: per-channel on-time limit, trip, cooldown and trip counter.
// Define TXGUARD_STICKY_EN to latch trips until a fault_clr pulse with the request released.
module wimpfi_txguard #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned MAX_ON_CYCLES = 2_000_000,
  parameter int unsigned COOL_CYCLES   = 1_000_000,
  parameter int unsigned CNT_W         = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       txen_req,
  input  logic                    force_fail,
  input  logic                    fault_clr,
  output logic [NUM_CH-1:0]       txen_safe,
  output logic [NUM_CH-1:0]       txen_fail,
  output logic [NUM_CH*CNT_W-1:0] tripcnt,
  output logic                    any_fail
);

  localparam int unsigned OnW   = $clog2(MAX_ON_CYCLES + 1);
  localparam int unsigned CoolW = $clog2(COOL_CYCLES + 1);

  localparam logic [OnW-1:0]   OnLast   = OnW'(MAX_ON_CYCLES - 1);
  localparam logic [CoolW-1:0] CoolLast = CoolW'(COOL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

`ifdef TXGUARD_STICKY_EN
  localparam bit Sticky = 1'b1;
`else
  localparam bit Sticky = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StOn, StTrip, StCool} state_e;

  state_e           state_q    [NUM_CH];
  state_e           state_d    [NUM_CH];
  logic [OnW-1:0]   on_cnt_q   [NUM_CH];
  logic [OnW-1:0]   on_cnt_d   [NUM_CH];
  logic [CoolW-1:0] cool_cnt_q [NUM_CH];
  logic [CoolW-1:0] cool_cnt_d [NUM_CH];
  logic [CNT_W-1:0] trip_cnt_q [NUM_CH];
  logic [CNT_W-1:0] trip_cnt_d [NUM_CH];

  logic [NUM_CH-1:0] safe_q, safe_d;
  logic [NUM_CH-1:0] fail_q, fail_d;
  logic              any_q, any_d;
  logic              trip_exit;

  // In sticky mode only an explicit clear with the request released leaves TRIP.
  assign trip_exit = !force_fail && (!Sticky || fault_clr);

  always_comb begin
    safe_d = '0;
    fail_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]    = state_q[i];
      on_cnt_d[i]   = on_cnt_q[i];
      cool_cnt_d[i] = cool_cnt_q[i];
      trip_cnt_d[i] = fault_clr ? '0 : trip_cnt_q[i];
      unique case (state_q[i])
        StIdle: begin
          if (txen_req[i] && !force_fail) begin
            state_d[i]  = StOn;
            on_cnt_d[i] = '0;
          end
        end
        StOn: begin
          if (!txen_req[i]) begin
            state_d[i] = StIdle;
          end else if (force_fail || (on_cnt_q[i] == OnLast)) begin
            state_d[i] = StTrip;
            // A coincident clear still leaves this trip counted.
            if (fault_clr) begin
              trip_cnt_d[i] = CntOne;
            end else if (trip_cnt_q[i] != CntMax) begin
              trip_cnt_d[i] = trip_cnt_q[i] + CntOne;
            end
          end else begin
            on_cnt_d[i] = on_cnt_q[i] + OnW'(1);
          end
        end
        StTrip: begin
          if (!txen_req[i] && trip_exit) begin
            state_d[i]    = StCool;
            cool_cnt_d[i] = '0;
          end
        end
        StCool: begin
          if (cool_cnt_q[i] == CoolLast) begin
            state_d[i] = StIdle;
          end else begin
            cool_cnt_d[i] = cool_cnt_q[i] + CoolW'(1);
          end
        end
        default: state_d[i] = StIdle;
      endcase
      safe_d[i] = (state_d[i] == StOn);
      fail_d[i] = (state_d[i] == StTrip);
    end
    any_d = |fail_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= StIdle;
        on_cnt_q[i]   <= '0;
        cool_cnt_q[i] <= '0;
        trip_cnt_q[i] <= '0;
      end
      safe_q <= '0;
      fail_q <= '0;
      any_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= state_d[i];
        on_cnt_q[i]   <= on_cnt_d[i];
        cool_cnt_q[i] <= cool_cnt_d[i];
        trip_cnt_q[i] <= trip_cnt_d[i];
      end
      safe_q <= safe_d;
      fail_q <= fail_d;
      any_q  <= any_d;
    end
  end

  assign txen_safe = safe_q;
  assign txen_fail = fail_q;
  assign any_fail  = any_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_tripcnt
    assign tripcnt[g*CNT_W +: CNT_W] = trip_cnt_q[g];
  end

endmodule

// File: tb/tb_wimpfi_txguard.sv
// Scoreboard bench for wimpfi_txguard (NUM_CH=2, MAX_ON_CYCLES=8, COOL_CYCLES=4, CNT_W=4).
module tb_wimpfi_txguard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] txen_req = '0;
  logic       force_fail = 1'b0;
  logic       fault_clr = 1'b0;
  logic [1:0] txen_safe;
  logic [1:0] txen_fail;
  logic [7:0] tripcnt;
  logic       any_fail;

  wimpfi_txguard #(
    .NUM_CH       (2),
    .MAX_ON_CYCLES(8),
    .COOL_CYCLES  (4),
    .CNT_W        (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .txen_req  (txen_req),
    .force_fail(force_fail),
    .fault_clr (fault_clr),
    .txen_safe (txen_safe),
    .txen_fail (txen_fail),
    .tripcnt   (tripcnt),
    .any_fail  (any_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] vec;  // {safe[1:0], fail[1:0], tripcnt[7:0], any}
    string       tag;
  } exp_t;

  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  string tag = "reset";

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic cyc(input logic [1:0] req, input logic ff, input logic clr, input logic r,
                     input logic [1:0] es, input logic [1:0] ef,
                     input logic [3:0] c0, input logic [3:0] c1);
    exp_t e;
    @(negedge clk);
    txen_req   = req;
    force_fail = ff;
    fault_clr  = clr;
    rst        = r;
    e.vec = {es, ef, c1, c0, |ef};
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t        e;
    logic [12:0] act;
    #1;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      act = {txen_safe, txen_fail, tripcnt, any_fail};
      checks++;
      if (act !== e.vec) begin
        errors++;
        $display("FAIL %s: got safe=%b fail=%b cnt=%h any=%b, want safe=%b fail=%b cnt=%h any=%b",
                 e.tag, act[12:11], act[10:9], act[8:1], act[0],
                 e.vec[12:11], e.vec[10:9], e.vec[8:1], e.vec[0]);
      end
    end
  end

  initial begin
    tag = "reset";
    repeat (2) cyc(2'b00, 0, 0, 1, 2'b00, 2'b00, 4'd0, 4'd0);

`ifndef TXGUARD_STICKY_EN
    tag = "short_frame";
    repeat (5) cyc(2'b01, 0, 0, 0, 2'b01, 2'b00, 4'd0, 4'd0);
    cyc(2'b00, 0, 0, 0, 2'b00, 2'b00, 4'd0, 4'd0);

    tag = "timeout_on";
    repeat (8) cyc(2'b01, 0, 0, 0, 2'b01, 2'b00, 4'd0, 4'd0);
    tag = "timeout_trip";
    repeat (12) cyc(2'b01, 0, 0, 0, 2'b00, 2'b01, 4'd1, 4'd0);
    tag = "cooldown";
    cyc(2'b00, 0, 0, 0, 2'b00, 2'b00, 4'd1, 4'd0);
    repeat (4) cyc(2'b01, 0, 0, 0, 2'b00, 2'b00, 4'd1, 4'd0);
    tag = "rearm";
    cyc(2'b01, 0, 0, 0, 2'b01, 2'b00, 4'd1, 4'd0);
    cyc(2'b00, 0, 0, 0, 2'b00, 2'b00, 4'd1, 4'd0);

    tag = "drop_vs_timeout";
    repeat (8) cyc(2'b01, 0, 0, 0, 2'b01, 2'b00, 4'd1, 4'd0);
    repeat (2) cyc(2'b00, 0, 0, 0, 2'b00, 2'b00, 4'd1, 4'd0);

    tag = "saturate";
    for (int k = 0; k < 17; k++) begin
      logic [3:0] old_c, new_c;
      old_c = (k > 15) ? 4'd15 : 4'(k);
      new_c = (k + 1 > 15) ? 4'd15 : 4'(k + 1);
      repeat (8) cyc(2'b10, 0, 0, 0, 2'b10, 2'b00, 4'd1, old_c);
      cyc(2'b10, 0, 0, 0, 2'b00, 2'b10, 4'd1, new_c);
      repeat (5) cyc(2'b00, 0, 0, 0, 2'b00, 2'b00, 4'd1, new_c);
    end

    tag = "clr_with_trip";
    repeat (8) cyc(2'b01, 0, 0, 0, 2'b01, 2'b00, 4'd1, 4'd15);
    cyc(2'b01, 0, 1, 0, 2'b00, 2'b01, 4'd1, 4'd0);
    repeat (5) cyc(2'b00, 0, 0, 0, 2'b00, 2'b00, 4'd1, 4'd0);
    tag = "fault_clr";
    cyc(2'b00, 0, 1, 0, 2'b00, 2'b00, 4'd0, 4'd0);

    tag = "force_fail";
    cyc(2'b01, 0, 0, 0, 2'b01, 2'b00, 4'd0, 4'd0);
    cyc(2'b11, 1, 0, 0, 2'b00, 2'b01, 4'd1, 4'd0);
    cyc(2'b00, 1, 0, 0, 2'b00, 2'b01, 4'd1, 4'd0);
    repeat (5) cyc(2'b00, 0, 0, 0, 2'b00, 2'b00, 4'd1, 4'd0);

    tag = "reset_mid";
    cyc(2'b01, 0, 0, 0, 2'b01, 2'b00, 4'd1, 4'd0);
    cyc(2'b01, 1, 0, 0, 2'b00, 2'b01, 4'd2, 4'd0);
    cyc(2'b00, 0, 0, 0, 2'b00, 2'b00, 4'd2, 4'd0);
    cyc(2'b10, 0, 0, 0, 2'b10, 2'b00, 4'd2, 4'd0);
    cyc(2'b10, 0, 0, 1, 2'b00, 2'b00, 4'd0, 4'd0);
    cyc(2'b11, 0, 0, 0, 2'b11, 2'b00, 4'd0, 4'd0);
    cyc(2'b00, 0, 0, 0, 2'b00, 2'b00, 4'd0, 4'd0);
`else
    tag = "sticky_on";
    repeat (8) cyc(2'b01, 0, 0, 0, 2'b01, 2'b00, 4'd0, 4'd0);
    tag = "sticky_trip";
    cyc(2'b01, 0, 0, 0, 2'b00, 2'b01, 4'd1, 4'd0);
    cyc(2'b01, 0, 1, 0, 2'b00, 2'b01, 4'd0, 4'd0);
    repeat (3) cyc(2'b00, 0, 0, 0, 2'b00, 2'b01, 4'd0, 4'd0);
    tag = "sticky_release";
    cyc(2'b00, 0, 1, 0, 2'b00, 2'b00, 4'd0, 4'd0);
    cyc(2'b00, 0, 0, 0, 2'b00, 2'b00, 4'd0, 4'd0);
    repeat (3) cyc(2'b01, 0, 0, 0, 2'b00, 2'b00, 4'd0, 4'd0);
    tag = "sticky_rearm";
    cyc(2'b01, 0, 0, 0, 2'b01, 2'b00, 4'd0, 4'd0);
    cyc(2'b00, 0, 0, 0, 2'b00, 2'b00, 4'd0, 4'd0);
`endif

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
